// File: rtl/stw_test_sequencer_if.sv
// STW self-test port bundle between the sequencer (master) and the systolic array (slave).
interface stw_test_sequencer_if #(
  parameter int unsigned ROWS      = 3,
  parameter int unsigned COLS      = 3,
  parameter int unsigned WORD_SIZE = 16
);
  logic                   stw_test_load_en;
  logic [WORD_SIZE-1:0]   stw_mult_op1;
  logic [WORD_SIZE-1:0]   stw_mult_op2;
  logic [WORD_SIZE-1:0]   stw_add_op;
  logic [WORD_SIZE-1:0]   stw_expected;
  logic                   stw_start;
  logic                   stw_complete;
  logic [ROWS*COLS-1:0]   stw_result_mat;

  modport master (
    output stw_test_load_en, stw_mult_op1, stw_mult_op2, stw_add_op, stw_expected, stw_start,
    input  stw_complete, stw_result_mat
  );

  modport slave (
    input  stw_test_load_en, stw_mult_op1, stw_mult_op2, stw_add_op, stw_expected, stw_start,
    output stw_complete, stw_result_mat
  );
endinterface

// File: rtl/stw_test_sequencer.sv
// Steps a table of MAC test vectors through the STW self-test port and
// accumulates a sticky per-PE fault map for the repair logic.
module stw_test_sequencer #(
  parameter int unsigned ROWS        = 3,
  parameter int unsigned COLS        = 3,
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned NUM_VECTORS = 4,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              start,
  input  logic [NUM_VECTORS*4*WORD_SIZE-1:0]                vec_table,
  stw_test_sequencer_if.master                              stw,
  output logic                                              busy,
  output logic                                              done,
  output logic                                              timeout_err,
  output logic [ROWS*COLS-1:0]                              fault_map,
  output logic [$clog2(ROWS*COLS+1)-1:0]                    fault_count,
  output logic [((NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1)-1:0] vec_idx
);

  localparam int unsigned PE_N  = ROWS * COLS;
  localparam int unsigned FC_W  = $clog2(PE_N + 1);
  localparam int unsigned IDX_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam int unsigned VEC_W = 4 * WORD_SIZE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STRT,
    S_WAIT,
    S_CAPT,
    S_DONE
  } state_t;

  state_t               state_q;
  logic                 load_en_q;
  logic                 strt_q;
  logic [VEC_W-1:0]     ops_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 timeout_q;
  logic [PE_N-1:0]      fault_map_q;
  logic [FC_W-1:0]      fault_count_q;
  logic [IDX_W-1:0]     vec_idx_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 complete_q;

  logic [VEC_W-1:0]     vec_arr [NUM_VECTORS];
  logic [PE_N-1:0]      fault_map_d;
  logic [IDX_W-1:0]     vec_idx_d;
  logic                 completion;
  logic                 last_vec;
  logic                 wait_expired;

  function automatic logic [FC_W-1:0] popcount(input logic [PE_N-1:0] m);
    logic [FC_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(PE_N); i++) begin
      c = c + FC_W'(m[i]);
    end
    return c;
  endfunction

  always_comb begin
    for (int v = 0; v < int'(NUM_VECTORS); v++) begin
      vec_arr[v] = vec_table[v*VEC_W +: VEC_W];
    end
  end

  // Only a fresh 0->1 edge counts; a level left high by the previous vector does not.
  assign completion   = stw.stw_complete & ~complete_q;
  assign fault_map_d  = fault_map_q | ~stw.stw_result_mat;
  assign vec_idx_d    = vec_idx_q + IDX_W'(1);
  assign last_vec     = (vec_idx_q == IDX_W'(NUM_VECTORS - 1));
  assign wait_expired = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      load_en_q     <= 1'b0;
      strt_q        <= 1'b0;
      ops_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      fault_map_q   <= '0;
      fault_count_q <= '0;
      vec_idx_q     <= '0;
      cnt_q         <= '0;
      complete_q    <= 1'b0;
    end else begin
      complete_q <= stw.stw_complete;
      load_en_q  <= 1'b0;
      strt_q     <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q       <= S_LOAD;
            fault_map_q   <= '0;
            fault_count_q <= '0;
            timeout_q     <= 1'b0;
            vec_idx_q     <= '0;
            busy_q        <= 1'b1;
            load_en_q     <= 1'b1;
            ops_q         <= vec_arr[0];
          end
        end
        S_LOAD: begin
          state_q <= S_STRT;
          strt_q  <= 1'b1;
        end
        S_STRT: begin
          state_q <= S_WAIT;
          cnt_q   <= '0;
        end
        S_WAIT: begin
          if (completion) begin
            state_q <= S_CAPT;
          end else if (wait_expired) begin
            state_q       <= S_DONE;
            timeout_q     <= 1'b1;
            done_q        <= 1'b1;
            fault_count_q <= popcount(fault_map_q);
            ops_q         <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_CAPT: begin
          fault_map_q <= fault_map_d;
          if (last_vec) begin
            state_q       <= S_DONE;
            done_q        <= 1'b1;
            fault_count_q <= popcount(fault_map_d);
            ops_q         <= '0;
          end else begin
            state_q   <= S_LOAD;
            vec_idx_q <= vec_idx_d;
            load_en_q <= 1'b1;
            ops_q     <= vec_arr[vec_idx_d];
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ops_q   <= '0;
        end
      endcase
    end
  end

  assign stw.stw_test_load_en = load_en_q;
  assign stw.stw_start        = strt_q;
  assign stw.stw_mult_op1     = ops_q[0*WORD_SIZE +: WORD_SIZE];
  assign stw.stw_mult_op2     = ops_q[1*WORD_SIZE +: WORD_SIZE];
  assign stw.stw_add_op       = ops_q[2*WORD_SIZE +: WORD_SIZE];
  assign stw.stw_expected     = ops_q[3*WORD_SIZE +: WORD_SIZE];

  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = timeout_q;
  assign fault_map   = fault_map_q;
  assign fault_count = fault_count_q;
  assign vec_idx     = vec_idx_q;

endmodule

// File: tb/tb_stw_test_sequencer.sv
// Directed bench for stw_test_sequencer with a small STW responder model.
module tb_stw_test_sequencer;

  localparam int unsigned ROWS = 3;
  localparam int unsigned COLS = 3;
  localparam int unsigned WS   = 16;
  localparam int unsigned NV   = 4;
  localparam int unsigned TO   = 64;
  localparam int unsigned PE   = ROWS * COLS;
  localparam int unsigned FCW  = 4;
  localparam int unsigned IW   = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [NV*4*WS-1:0]   vec_table;
  logic                 busy;
  logic                 done;
  logic                 timeout_err;
  logic [PE-1:0]        fault_map;
  logic [FCW-1:0]       fault_count;
  logic [IW-1:0]        vec_idx;

  stw_test_sequencer_if #(.ROWS(ROWS), .COLS(COLS), .WORD_SIZE(WS)) stw_bus ();

  stw_test_sequencer #(
    .ROWS(ROWS), .COLS(COLS), .WORD_SIZE(WS), .NUM_VECTORS(NV), .TIMEOUT(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .vec_table   (vec_table),
    .stw         (stw_bus),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .fault_map   (fault_map),
    .fault_count (fault_count),
    .vec_idx     (vec_idx)
  );

  always #5 clk = ~clk;

  logic [WS-1:0] v_op1 [NV] = '{16'd4,  16'd5,  16'd2,  16'd9};
  logic [WS-1:0] v_op2 [NV] = '{16'd3,  16'd6,  16'd7,  16'd9};
  logic [WS-1:0] v_add [NV] = '{16'd0,  16'd1,  16'd3,  16'd0};
  logic [WS-1:0] v_exp [NV] = '{16'd12, 16'd31, 16'd17, 16'd81};
  logic [PE-1:0] rmat  [NV];

  int n_checks = 0;
  int n_pass   = 0;
  int load_cnt = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int wait_cnt = 0;
  bit in_wait  = 1'b0;
  int resp_mode = 1;   // 0 normal responder, 1 complete held 0, 2 complete held 1
  int delay_cnt = 0;
  bit pending  = 1'b0;
  bit got_done;
  logic [FCW-1:0] fc_at_done;
  logic [IW-1:0]  idx_at_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // STW array stand-in: completes 5 cycles after stw_start with the scripted result map.
  initial begin
    stw_bus.stw_complete   = 1'b0;
    stw_bus.stw_result_mat = '1;
    forever begin
      @(negedge clk);
      if (resp_mode == 0) begin
        if (stw_bus.stw_test_load_en) stw_bus.stw_complete = 1'b0;
        if (stw_bus.stw_start) begin
          delay_cnt = 5;
          pending   = 1'b1;
        end else if (pending) begin
          delay_cnt--;
          if (delay_cnt == 0) begin
            pending = 1'b0;
            stw_bus.stw_result_mat = rmat[vec_idx];
            stw_bus.stw_complete   = 1'b1;
          end
        end
      end else begin
        pending = 1'b0;
        stw_bus.stw_complete = (resp_mode == 2);
      end
    end
  end

  // Pulse counters plus operand checks on every load/start pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (stw_bus.stw_test_load_en) begin
        check("load_op1", stw_bus.stw_mult_op1, v_op1[load_cnt % NV]);
        check("load_op2", stw_bus.stw_mult_op2, v_op2[load_cnt % NV]);
        check("load_add", stw_bus.stw_add_op,   v_add[load_cnt % NV]);
        check("load_exp", stw_bus.stw_expected, v_exp[load_cnt % NV]);
        check("load_idx", vec_idx, load_cnt);
        load_cnt++;
      end
      if (stw_bus.stw_start) begin
        check("strt_op1_held", stw_bus.stw_mult_op1, v_op1[vec_idx]);
        start_cnt++;
        wait_cnt = 0;
        in_wait  = 1'b1;
      end else if (in_wait) begin
        if (done) in_wait = 1'b0;
        else wait_cnt++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic run_and_wait();
    int n;
    load_cnt  = 0;
    start_cnt = 0;
    done_cnt  = 0;
    got_done  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!got_done && n < 1000) begin
      @(negedge clk);
      n++;
      if (done) begin
        got_done    = 1'b1;
        fc_at_done  = fault_count;
        idx_at_done = vec_idx;
      end
    end
    if (!got_done) check("done_wait_bound", 32'd0, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic expect_run(input int loads, input int starts, input logic [PE-1:0] fm,
                            input int fc, input bit to, input int idx);
    check("done_once",        done_cnt, 1);
    check("load_pulses",      load_cnt, loads);
    check("start_pulses",     start_cnt, starts);
    check("fault_map",        fault_map, fm);
    check("fault_count_done", fc_at_done, fc);
    check("fault_count_hold", fault_count, fc);
    check("timeout_err",      timeout_err, to);
    check("idx_at_done",      idx_at_done, idx);
    check("busy_after",       busy, 0);
    check("op1_idle",         stw_bus.stw_mult_op1, 0);
  endtask

  task automatic set_rmat(input logic [PE-1:0] r0, input logic [PE-1:0] r1,
                          input logic [PE-1:0] r2, input logic [PE-1:0] r3);
    rmat[0] = r0; rmat[1] = r1; rmat[2] = r2; rmat[3] = r3;
  endtask

  initial begin
    int n;
    for (int v = 0; v < int'(NV); v++)
      vec_table[v*4*WS +: 4*WS] = {v_exp[v], v_add[v], v_op2[v], v_op1[v]};
    set_rmat(9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF);
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_busy",    busy, 0);
    check("rst_done",    done, 0);
    check("rst_load_en", stw_bus.stw_test_load_en, 0);
    check("rst_start",   stw_bus.stw_start, 0);
    check("rst_fmap",    fault_map, 0);
    check("rst_idx",     vec_idx, 0);

    // 1: all PEs pass
    resp_mode = 0;
    repeat (2) @(negedge clk);
    run_and_wait();
    expect_run(4, 4, 9'h000, 0, 1'b0, 3);

    // 2: single fault on vector 2
    set_rmat(9'h1FF, 9'h1FF, 9'h1FD, 9'h1FF);
    run_and_wait();
    expect_run(4, 4, 9'h002, 1, 1'b0, 3);

    // 3: faults from two vectors merge
    set_rmat(9'h1FE, 9'h1FF, 9'h1FF, 9'h0FF);
    run_and_wait();
    expect_run(4, 4, 9'h101, 2, 1'b0, 3);

    // 4: complete never rises
    resp_mode = 1;
    repeat (2) @(negedge clk);
    run_and_wait();
    expect_run(1, 1, 9'h000, 0, 1'b1, 0);
    check("timeout_wait_cycles", wait_cnt, TO);

    // 5: complete stuck high is never a completion
    resp_mode = 2;
    repeat (2) @(negedge clk);
    run_and_wait();
    expect_run(1, 1, 9'h000, 0, 1'b1, 0);
    check("stuck_wait_cycles", wait_cnt, TO);

    // clean run after a timeout clears timeout_err
    resp_mode = 0;
    set_rmat(9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF);
    repeat (2) @(negedge clk);
    run_and_wait();
    expect_run(4, 4, 9'h000, 0, 1'b0, 3);

    // 6: start during WAIT ignored, then reset in WAIT of vector 1
    load_cnt = 0; start_cnt = 0; done_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!stw_bus.stw_start && n < 50) begin @(negedge clk); n++; end
    check("abuse_strt0_seen", stw_bus.stw_start, 1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!stw_bus.stw_start && n < 50) begin @(negedge clk); n++; end
    check("abuse_strt1_seen", stw_bus.stw_start, 1);
    check("abuse_strt1_idx",  vec_idx, 1);
    @(negedge clk);
    check("abuse_loads", load_cnt, 2);
    resp_mode = 1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy",    busy, 0);
    check("abort_done",    done, 0);
    check("abort_load_en", stw_bus.stw_test_load_en, 0);
    check("abort_start",   stw_bus.stw_start, 0);
    check("abort_op1",     stw_bus.stw_mult_op1, 0);
    check("abort_exp",     stw_bus.stw_expected, 0);
    check("abort_idx",     vec_idx, 0);
    check("abort_fmap",    fault_map, 0);
    check("abort_fcount",  fault_count, 0);
    check("abort_timeout", timeout_err, 0);
    check("abort_no_done", done_cnt, 0);
    resp_mode = 0;
    repeat (3) @(negedge clk);
    run_and_wait();
    expect_run(4, 4, 9'h000, 0, 1'b0, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
